aes_encrypt_core: RTL and testbench
===================================

AES_ENCRYPT_CORE -- requirements
Module: aes_encrypt_core

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request to encrypt; sampled only in IDLE.
REQ-004 SHALL have port key, input, 256 bits: cipher key, MSB-aligned (128-bit key in [255:128], 192-bit key in [255:64]).
REQ-005 SHALL have port mux, input, 2 bits: key size (00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = reserved).
REQ-006 SHALL have port in_state, input, 128 bits: plaintext block, byte 0 in [127:120].
REQ-007 SHALL have port out_state, output, 128 bits: ciphertext block.
REQ-008 SHALL have port counter, output, 4 bits: current round number.
REQ-009 SHALL have port busy, output, 1 bit: high from start acceptance until DONE is reached.
REQ-010 SHALL have port finishEncrypt, output, 1 bit: one-cycle completion pulse.

Function
REQ-011 SHALL take Nk/Nr as 4/10, 6/12 and 8/14 for key sizes 128, 192 and 256.
REQ-012 SHALL implement the states IDLE, KEYEXP, ADDKEY0, ROUND, FINAL and DONE.
REQ-013 SHALL, in IDLE with start=1 and mux!=11, capture key, mux and in_state, load key words w[0..Nk-1], and enter KEYEXP.
REQ-014 SHALL, in IDLE with start=1 and mux=11, ignore start and remain in IDLE.
REQ-015 SHALL, in KEYEXP, compute one schedule word per cycle (FIPS-197 RotWord/SubWord/Rcon, plus the extra SubWord when Nk=8 and i mod 8 = 4) for i = Nk..4Nr+3, i.e. 40, 46 or 52 cycles, then enter ADDKEY0.
REQ-016 SHALL, in ADDKEY0, XOR the captured state with round key 0, set counter=1, and enter ROUND.
REQ-017 SHALL, in ROUND, apply SubBytes, ShiftRows, MixColumns and AddRoundKey(counter), increment counter, and enter FINAL when counter=Nr-1.
REQ-018 SHALL, in FINAL, apply SubBytes, ShiftRows and AddRoundKey(Nr) without MixColumns, load the result into out_state, and enter DONE.
REQ-019 SHALL, in DONE, assert finishEncrypt for exactly one cycle, deassert busy, and return to IDLE.
REQ-020 SHALL produce total latency, counted from the start-sampling edge to the edge after which finishEncrypt is high, of 51 cycles (AES-128), 59 cycles (AES-192) and 67 cycles (AES-256).
REQ-021 SHALL hold out_state unchanged except at the FINAL-to-DONE edge; the value remains valid until the next completion.
REQ-022 SHALL ignore start while busy=1, and SHALL ignore changes on key, mux and in_state after capture.
REQ-023 SHALL allow a new start to be accepted in the IDLE cycle immediately following DONE (back-to-back operation).
REQ-024 SHALL hold counter at 0 in IDLE and KEYEXP.

Reset
REQ-025 SHALL, at a rising edge of clk with reset=1, enter IDLE and clear out_state, counter, busy and finishEncrypt to 0, regardless of state.
REQ-026 SHALL discard any in-progress operation on reset, and SHALL NOT pulse finishEncrypt for the discarded operation.
REQ-027 SHALL give reset priority over start when both are high on the same edge.

Structure
REQ-028 SHALL place the S-box function, Rcon table, key-size encodings, the Nk/Nr constants and the FSM state encodings in shared package aes_pkg.
REQ-029 SHALL instantiate one combinational sub-module, aes_enc_round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey, with a final-round bypass input).
REQ-030 SHALL hold the key schedule in an internal array of 60 x 32-bit words.

Verification
REQ-031 SHALL cover AES-128: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_state 69c4e0d86a7b0430d8cdb78070b4c55a, finishEncrypt at cycle 51.
REQ-032 SHALL cover AES-192: key 000102...1617, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191, finishEncrypt at cycle 59.
REQ-033 SHALL cover AES-256: key 000102...1e1f, same pt -> 8ea2b7ca516745bfeafc49904b496089, finishEncrypt at cycle 67.
REQ-034 SHALL cover reset mid-operation: reset pulsed at cycle 20 of an AES-128 run -> IDLE, all outputs 0, no finishEncrypt; a fresh start then completes correctly.
REQ-035 SHALL cover busy and invalid inputs: start re-pulsed while busy, and start with mux=11 -> each ignored, with busy/state unchanged and no extra finishEncrypt.
REQ-036 SHALL cover back-to-back operation: an AES-256 run started in the IDLE cycle after an AES-128 DONE -> both ciphertexts correct, and out_state holds the first result until the second completes.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-size and FSM encodings, round constants and the
// byte substitution used by both the key schedule and the round datapath.
package aes_pkg;

   typedef enum logic [1:0] {
      KS_128  = 2'b00,
      KS_192  = 2'b01,
      KS_256  = 2'b10,
      KS_RSVD = 2'b11
   } key_size_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEYEXP,
      ST_ADDKEY0,
      ST_ROUND,
      ST_FINAL,
      ST_DONE
   } state_e;

   localparam int NUM_WORDS = 60;

   // Forward S-box, entry 0x00 in the most significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [3:0] nk_of(input key_size_e ks);
      case (ks)
         KS_128:  return 4'd4;
         KS_192:  return 4'd6;
         default: return 4'd8;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input key_size_e ks);
      case (ks)
         KS_128:  return 4'd10;
         KS_192:  return 4'd12;
         default: return 4'd14;
      endcase
   endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational encryption round; final_i drops MixColumns for the last round.
module aes_enc_round
   import aes_pkg::*;
(
   input  logic [127:0] state_i,
   input  logic [127:0] round_key_i,
   input  logic         final_i,
   output logic [127:0] state_o
);

   logic [7:0] sb [16];
   logic [7:0] sr [16];
   logic [7:0] mc [16];

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      sb      = '{default: 8'h00};
      sr      = '{default: 8'h00};
      mc      = '{default: 8'h00};
      state_o = '0;
      for (int k = 0; k < 16; k++) sb[k] = sbox(state_i[127 - 8*k -: 8]);
      // Byte k sits in row k%4, column k/4; row r rotates left by r columns.
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[4*c + r] = sb[4*((c + r) % 4) + r];
      for (int c = 0; c < 4; c++) begin
         mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
         mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
      end
      for (int k = 0; k < 16; k++)
         state_o[127 - 8*k -: 8] = (final_i ? sr[k] : mc[k]) ^ round_key_i[127 - 8*k -: 8];
   end

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128/192/256 encryptor: one key-schedule word per cycle, then
// one round per cycle through a shared combinational round.
module aes_encrypt_core
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [255:0] key,
   input  logic [1:0]   mux,
   input  logic [127:0] in_state,
   output logic [127:0] out_state,
   output logic [3:0]   counter,
   output logic         busy,
   output logic         finishEncrypt
);

   state_e       fsm_q;
   key_size_e    ks_q;
   logic [127:0] st_q;
   logic [127:0] out_q;
   logic [3:0]   cnt_q;
   logic [3:0]   rc_q;
   logic [5:0]   wi_q;
   logic [2:0]   kpos_q;
   logic         busy_q;
   logic         fin_q;
   logic [31:0]  w_q [NUM_WORDS];

   logic         start_ok_d;
   logic [3:0]   nk_d;
   logic [3:0]   nr_d;
   logic [5:0]   last_wi_d;
   logic [5:0]   rk_base_d;
   logic [31:0]  w_prev_d;
   logic [31:0]  w_back_d;
   logic [31:0]  w_tmp_d;
   logic [31:0]  w_new_d;
   logic [127:0] rk_d;
   logic [127:0] round_d;

   assign start_ok_d = start && (key_size_e'(mux) != KS_RSVD);
   assign nk_d       = nk_of(ks_q);
   assign nr_d       = nr_of(ks_q);
   assign last_wi_d  = {nr_d, 2'b00} + 6'd3;

   assign w_prev_d = w_q[wi_q - 6'd1];
   assign w_back_d = w_q[wi_q - {2'b00, nk_d}];

   // kpos_q tracks i mod Nk so no divider is needed.
   always_comb begin
      w_tmp_d = w_prev_d;
      if (kpos_q == 3'd0)
         w_tmp_d = sub_word(rot_word(w_prev_d)) ^ {rcon(rc_q), 24'h000000};
      else if (nk_d == 4'd8 && kpos_q == 3'd4)
         w_tmp_d = sub_word(w_prev_d);
   end

   assign w_new_d   = w_back_d ^ w_tmp_d;
   assign rk_base_d = {cnt_q, 2'b00};
   assign rk_d      = {w_q[rk_base_d], w_q[rk_base_d + 6'd1],
                       w_q[rk_base_d + 6'd2], w_q[rk_base_d + 6'd3]};

   aes_enc_round u_round (
      .state_i     (st_q),
      .round_key_i (rk_d),
      .final_i     (fsm_q == ST_FINAL),
      .state_o     (round_d)
   );

   // NOTE: the key schedule is plain storage, overwritten before use, so it carries no reset.
   always_ff @(posedge clk) begin
      if (fsm_q == ST_IDLE && start_ok_d) begin
         for (int j = 0; j < 8; j++)
            if (j < int'(nk_of(key_size_e'(mux)))) w_q[j] <= key[255 - 32*j -: 32];
      end else if (fsm_q == ST_KEYEXP) begin
         w_q[wi_q] <= w_new_d;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q  <= ST_IDLE;
         ks_q   <= KS_128;
         st_q   <= '0;
         out_q  <= '0;
         cnt_q  <= 4'd0;
         rc_q   <= 4'd1;
         wi_q   <= 6'd0;
         kpos_q <= 3'd0;
         busy_q <= 1'b0;
         fin_q  <= 1'b0;
      end else begin
         case (fsm_q)
            ST_IDLE: begin
               fin_q <= 1'b0;
               cnt_q <= 4'd0;
               if (start_ok_d) begin
                  ks_q   <= key_size_e'(mux);
                  st_q   <= in_state;
                  wi_q   <= {2'b00, nk_of(key_size_e'(mux))};
                  kpos_q <= 3'd0;
                  rc_q   <= 4'd1;
                  busy_q <= 1'b1;
                  fsm_q  <= ST_KEYEXP;
               end
            end
            ST_KEYEXP: begin
               kpos_q <= ({1'b0, kpos_q} == nk_d - 4'd1) ? 3'd0 : kpos_q + 3'd1;
               if (kpos_q == 3'd0) rc_q <= rc_q + 4'd1;
               if (wi_q == last_wi_d) fsm_q <= ST_ADDKEY0;
               else                   wi_q  <= wi_q + 6'd1;
            end
            ST_ADDKEY0: begin
               st_q  <= st_q ^ rk_d;
               cnt_q <= 4'd1;
               fsm_q <= ST_ROUND;
            end
            ST_ROUND: begin
               st_q  <= round_d;
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == nr_d - 4'd1) fsm_q <= ST_FINAL;
            end
            ST_FINAL: begin
               out_q  <= round_d;
               fin_q  <= 1'b1;
               busy_q <= 1'b0;
               fsm_q  <= ST_DONE;
            end
            ST_DONE: begin
               fin_q <= 1'b0;
               cnt_q <= 4'd0;
               fsm_q <= ST_IDLE;
            end
            default: fsm_q <= ST_IDLE;
         endcase
      end
   end

   assign out_state     = out_q;
   assign counter       = cnt_q;
   assign busy          = busy_q;
   assign finishEncrypt = fin_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Scoreboard bench for aes_encrypt_core: known-answer vectors plus random
// blocks checked against an algebraic AES model.
module tb_aes_encrypt_core;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [255:0] key;
   logic [1:0]   mux;
   logic [127:0] in_state;
   logic [127:0] out_state;
   logic [3:0]   counter;
   logic         busy;
   logic         finishEncrypt;

   aes_encrypt_core dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .key           (key),
      .mux           (mux),
      .in_state      (in_state),
      .out_state     (out_state),
      .counter       (counter),
      .busy          (busy),
      .finishEncrypt (finishEncrypt)
   );

   always #5 clk = ~clk;

   localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

   typedef struct {
      logic [127:0] ct;
      int           lat;
      int           sc;
   } exp_t;

   exp_t         sb_q[$];
   exp_t         mon_e;
   int           cyc = 0;
   logic         rst_edge = 1'b1;
   int           compared = 0;
   int           mismatched = 0;
   int           fin_cnt = 0;
   int           last_sc = 0;
   logic [127:0] prev_out = '0;
   logic [7:0]   sbox_t [256];

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_edge <= reset;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
         end
         sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                     {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_model(input logic [255:0] k, input logic [1:0] m,
                                              input logic [127:0] pt);
      int           nk;
      int           nr;
      logic [7:0]   w [240];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   tw [4];
      logic [7:0]   tmp;
      logic [7:0]   rc;
      logic [127:0] res;
      nk = (m == 2'd0) ? 4 : (m == 2'd1) ? 6 : 8;
      nr = nk + 6;
      for (int i = 0; i < 4*nk; i++) w[i] = k[255 - 8*i -: 8];
      rc = 8'h01;
      for (int i = nk; i < 4*(nr + 1); i++) begin
         for (int j = 0; j < 4; j++) tw[j] = w[4*(i-1) + j];
         if (i % nk == 0) begin
            tmp   = tw[0];
            tw[0] = sbox_t[tw[1]] ^ rc;
            tw[1] = sbox_t[tw[2]];
            tw[2] = sbox_t[tw[3]];
            tw[3] = sbox_t[tmp];
            rc    = gmul(rc, 8'h02);
         end else if (nk == 8 && i % nk == 4) begin
            for (int j = 0; j < 4; j++) tw[j] = sbox_t[tw[j]];
         end
         for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-nk) + j] ^ tw[j];
      end
      for (int b = 0; b < 16; b++) s[b] = pt[127 - 8*b -: 8] ^ w[b];
      for (int r = 1; r <= nr; r++) begin
         for (int b = 0; b < 16; b++) t[b] = sbox_t[s[b]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) s[4*c + row] = t[4*((c + row) % 4) + row];
         if (r != nr) begin
            for (int c = 0; c < 4; c++) begin
               t[4*c+0] = gmul(s[4*c], 8'h02) ^ gmul(s[4*c+1], 8'h03) ^ s[4*c+2] ^ s[4*c+3];
               t[4*c+1] = s[4*c] ^ gmul(s[4*c+1], 8'h02) ^ gmul(s[4*c+2], 8'h03) ^ s[4*c+3];
               t[4*c+2] = s[4*c] ^ s[4*c+1] ^ gmul(s[4*c+2], 8'h02) ^ gmul(s[4*c+3], 8'h03);
               t[4*c+3] = gmul(s[4*c], 8'h03) ^ s[4*c+1] ^ s[4*c+2] ^ gmul(s[4*c+3], 8'h02);
            end
            for (int b = 0; b < 16; b++) s[b] = t[b];
         end
         for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[16*r + b];
      end
      for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = s[b];
      return res;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (out_state !== prev_out) begin
         if (!rst_edge) check("out_state_hold", 128'(finishEncrypt), 128'd1);
         prev_out = out_state;
      end
      if (finishEncrypt) begin
         fin_cnt++;
         if (sb_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_finish: out_state=%h with no request pending (cycle %0d)",
                     out_state, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            check("ciphertext", out_state, mon_e.ct);
            check("latency", 128'(cyc - mon_e.sc), 128'(mon_e.lat));
            check("busy_in_done", 128'(busy), 128'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   // Called on a falling edge; start is sampled on the following rising edge.
   task automatic start_op(input logic [255:0] k, input logic [1:0] m, input logic [127:0] pt,
                           input logic [127:0] ct);
      exp_t e;
      start    = 1'b1;
      key      = k;
      mux      = m;
      in_state = pt;
      e.ct     = ct;
      e.lat    = (m == 2'd0) ? 51 : (m == 2'd1) ? 59 : 67;
      e.sc     = cyc + 1;
      last_sc  = cyc + 1;
      sb_q.push_back(e);
      @(negedge clk);
      start    = 1'b0;
      key      = rand256();
      mux      = 2'($urandom_range(0, 3));
      in_state = rand128();
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("completion_in_time", 128'(n < budget), 128'd1);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [255:0] k;
      logic [127:0] p;
      logic [127:0] ct1;
      logic [1:0]   m;
      int           saved;
      int           n;

      build_sbox();
      reset    = 1'b1;
      start    = 1'b0;
      key      = '0;
      mux      = 2'd0;
      in_state = '0;
      repeat (3) @(negedge clk);
      check("reset_out_state", out_state, 128'd0);
      check("reset_counter", 128'(counter), 128'd0);
      check("reset_busy", 128'(busy), 128'd0);
      check("reset_finish", 128'(finishEncrypt), 128'd0);
      reset = 1'b0;

      // Known-answer vectors
      @(negedge clk); start_op(K128, 2'd0, PT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a); wait_done(200);
      @(negedge clk); start_op(K192, 2'd1, PT, 128'hdda97ca4864cdfe06eaf70a0ec0d7191); wait_done(200);
      @(negedge clk); start_op(K256, 2'd2, PT, 128'h8ea2b7ca516745bfeafc49904b496089); wait_done(200);

      // start re-pulsed while busy, in KEYEXP and in ROUND
      @(negedge clk);
      k = rand256(); p = rand128();
      start_op(k, 2'd0, p, aes_model(k, 2'd0, p));
      wait_cyc(last_sc + 10);
      check("counter_in_keyexp", 128'(counter), 128'd0);
      start = 1'b1; mux = 2'd1; key = rand256();
      @(negedge clk);
      start = 1'b0;
      check("busy_after_repulse_keyexp", 128'(busy), 128'd1);
      check("counter_after_repulse_keyexp", 128'(counter), 128'd0);
      wait_cyc(last_sc + 45);
      check("counter_in_round", 128'(counter), 128'd5);
      start = 1'b1; mux = 2'd2; key = rand256();
      @(negedge clk);
      start = 1'b0;
      check("counter_after_repulse_round", 128'(counter), 128'd6);
      check("busy_after_repulse_round", 128'(busy), 128'd1);
      wait_done(200);

      // Reserved key size is ignored
      @(negedge clk);
      saved = fin_cnt;
      start = 1'b1; mux = 2'd3; key = rand256(); in_state = rand128();
      @(negedge clk);
      start = 1'b0;
      check("busy_after_reserved_mux", 128'(busy), 128'd0);
      check("counter_after_reserved_mux", 128'(counter), 128'd0);
      repeat (60) @(negedge clk);
      check("no_finish_reserved_mux", 128'(fin_cnt), 128'(saved));

      // Reset at cycle 20 of an AES-128 run
      @(negedge clk);
      start_op(K128, 2'd0, PT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      wait_cyc(last_sc + 19);
      reset = 1'b1;
      sb_q.delete();
      saved = fin_cnt;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_out_state", out_state, 128'd0);
      check("midreset_counter", 128'(counter), 128'd0);
      check("midreset_busy", 128'(busy), 128'd0);
      check("midreset_finish", 128'(finishEncrypt), 128'd0);
      repeat (80) @(negedge clk);
      check("no_finish_after_reset", 128'(fin_cnt), 128'(saved));
      @(negedge clk);
      start_op(K128, 2'd0, PT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      wait_done(200);

      // Back-to-back: AES-256 accepted in the IDLE cycle right after an AES-128 DONE
      @(negedge clk);
      k = rand256(); p = rand128();
      ct1 = aes_model(k, 2'd0, p);
      start_op(k, 2'd0, p, ct1);
      n = 0;
      while (!finishEncrypt && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first_done", 128'(n < 200), 128'd1);
      @(negedge clk);
      k = rand256(); p = rand128();
      start_op(k, 2'd2, p, aes_model(k, 2'd2, p));
      wait_cyc(last_sc + 30);
      check("b2b_hold_first_result", out_state, ct1);
      wait_done(200);

      // Random blocks across all key sizes
      for (int it = 0; it < 12; it++) begin
         repeat (1 + $urandom_range(0, 3)) @(negedge clk);
         m = 2'($urandom_range(0, 2));
         k = rand256(); p = rand128();
         start_op(k, m, p, aes_model(k, m, p));
         wait_done(200);
      end

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
